// File: rtl/multi_channel_key_pwm_pkg.sv
// Shared key indices, key-FSM state encoding and the saturating duty-step
// helper for the multi-channel key PWM.
package multi_channel_key_pwm_pkg;

  localparam logic [2:0] KEY_NEXT = 3'd5;
  localparam logic [2:0] KEY_UP_C = 3'd4;
  localparam logic [2:0] KEY_DN_C = 3'd3;
  localparam logic [2:0] KEY_UP_F = 3'd2;
  localparam logic [2:0] KEY_DN_F = 3'd1;
  localparam logic [2:0] KEY_HALF = 3'd0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } key_state_t;

  // One bit wider than the operands so the up-step clamps instead of wrapping.
  function automatic logic [31:0] sat_adjust(input logic [31:0] duty,
                                             input logic [31:0] step,
                                             input logic [31:0] max_val,
                                             input logic        up);
    logic [32:0] sum;
    sum = {1'b0, duty} + {1'b0, step};
    if (up) begin
      return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
    end
    return (duty < step) ? 32'd0 : (duty - step);
  endfunction

endpackage

// File: rtl/multi_channel_key_pwm_key_repeat_fsm.sv
// Key latch with hold-to-auto-repeat; emits one registered event pulse per
// press and periodic repeats for the adjust keys only.
//   state     | meaning
//   ST_IDLE   | no key latched, waiting for any key
//   ST_DELAY  | key latched, counting down the initial hold delay
//   ST_REPEAT | key still held, counting down between repeat events
module key_repeat_fsm
  import multi_channel_key_pwm_pkg::*;
#(
  parameter int HOLD_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 5000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] Key_In,
  output logic       event_valid,
  output logic [2:0] event_key
);

  localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LOAD = CNT_W'(REPEAT_CYCLES - 1);

  key_state_t       r_state;
  key_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       r_key;
  logic [2:0]       w_key_nxt;
  logic [2:0]       w_key_hi;
  logic [2:0]       w_evt_key_nxt;
  logic             w_evt_nxt;
  logic             w_key_held;
  logic             w_repeatable;
  logic             w_cnt_done;
  logic             r_evt;
  logic [2:0]       r_evt_key;

  // Highest asserted index wins when several keys arrive together.
  always_comb begin
    w_key_hi = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (Key_In[i]) w_key_hi = 3'(i);
    end
  end

  assign w_key_held   = Key_In[r_key];
  assign w_repeatable = (r_key >= KEY_DN_F) && (r_key <= KEY_UP_C);
  assign w_cnt_done   = (r_cnt == '0);

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_key_nxt     = r_key;
    w_evt_nxt     = 1'b0;
    w_evt_key_nxt = r_key;
    case (r_state)
      ST_IDLE: begin
        if (|Key_In) begin
          w_key_nxt     = w_key_hi;
          w_evt_key_nxt = w_key_hi;
          w_evt_nxt     = 1'b1;
          w_state_nxt   = ST_DELAY;
          w_cnt_nxt     = HOLD_LOAD;
        end
      end
      ST_DELAY, ST_REPEAT: begin
        if (!w_key_held) begin
          w_state_nxt = ST_IDLE;
        end else if (w_cnt_done) begin
          w_evt_nxt   = w_repeatable;
          w_state_nxt = ST_REPEAT;
          w_cnt_nxt   = REPEAT_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_key     <= 3'd0;
      r_evt     <= 1'b0;
      r_evt_key <= 3'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_key     <= w_key_nxt;
      r_evt     <= w_evt_nxt;
      r_evt_key <= w_evt_key_nxt;
    end
  end

  assign event_valid = r_evt;
  assign event_key   = r_evt_key;

endmodule

// File: rtl/multi_channel_key_pwm.sv
// Multi-channel PWM with key-adjusted, double-buffered duties; pending duties
// are copied to the active set only at the period boundary.
module multi_channel_key_pwm
  import multi_channel_key_pwm_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int WIDTH         = 8,
  parameter int PRESCALE      = 195,
  parameter int STEP_FINE     = 1,
  parameter int STEP_COARSE   = 10,
  parameter int HOLD_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 5000000,
  localparam int SEL_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [5:0]          Key_In,
  output logic [CHANNELS-1:0] PWM_Out,
  output logic [SEL_W-1:0]    Sel_Ch,
  output logic [WIDTH-1:0]    Sel_Duty
);

  localparam int MAX   = (1 << WIDTH) - 1;
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] SLOT_LAST = WIDTH'(MAX - 1);
  localparam logic [WIDTH-1:0] DUTY_HALF = WIDTH'(MAX >> 1);
  localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(CHANNELS - 1);

  logic [PRE_W-1:0]    r_pre;
  logic [WIDTH-1:0]    r_slot;
  logic [WIDTH-1:0]    r_pend [CHANNELS];
  logic [WIDTH-1:0]    r_act  [CHANNELS];
  logic [SEL_W-1:0]    r_sel;
  logic [CHANNELS-1:0] r_pwm;
  logic                w_tick;
  logic                w_period_start;
  logic                w_evt_valid;
  logic [2:0]          w_evt_key;
  logic [WIDTH-1:0]    w_cur_duty;
  logic [WIDTH-1:0]    w_duty_nxt;
  logic [SEL_W-1:0]    w_sel_nxt;

  key_repeat_fsm #(
    .HOLD_CYCLES   (HOLD_CYCLES),
    .REPEAT_CYCLES (REPEAT_CYCLES)
  ) u_key_fsm (
    .CLK         (CLK),
    .RST         (RST),
    .Key_In      (Key_In),
    .event_valid (w_evt_valid),
    .event_key   (w_evt_key)
  );

  assign w_tick         = (r_pre == PRE_LAST);
  assign w_period_start = w_tick && (r_slot == SLOT_LAST);
  assign w_cur_duty     = r_pend[r_sel];

  always_comb begin
    w_duty_nxt = w_cur_duty;
    w_sel_nxt  = r_sel;
    if (w_evt_valid) begin
      case (w_evt_key)
        KEY_NEXT: w_sel_nxt  = (r_sel == SEL_LAST) ? '0 : r_sel + 1'b1;
        KEY_UP_C: w_duty_nxt = WIDTH'(sat_adjust(32'(w_cur_duty), 32'(STEP_COARSE), 32'(MAX), 1'b1));
        KEY_DN_C: w_duty_nxt = WIDTH'(sat_adjust(32'(w_cur_duty), 32'(STEP_COARSE), 32'(MAX), 1'b0));
        KEY_UP_F: w_duty_nxt = WIDTH'(sat_adjust(32'(w_cur_duty), 32'(STEP_FINE), 32'(MAX), 1'b1));
        KEY_DN_F: w_duty_nxt = WIDTH'(sat_adjust(32'(w_cur_duty), 32'(STEP_FINE), 32'(MAX), 1'b0));
        KEY_HALF: w_duty_nxt = DUTY_HALF;
        default:  w_duty_nxt = w_cur_duty;
      endcase
    end
  end

  // One period spans MAX slots, so the slot counter never reaches MAX itself.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pre  <= '0;
      r_slot <= '0;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
      if (w_tick) r_slot <= (r_slot == SLOT_LAST) ? '0 : r_slot + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sel <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        r_pend[i] <= '0;
        r_act[i]  <= '0;
      end
    end else begin
      r_sel <= w_sel_nxt;
      if (w_evt_valid) r_pend[r_sel] <= w_duty_nxt;
      if (w_period_start) begin
        for (int i = 0; i < CHANNELS; i++) r_act[i] <= r_pend[i];
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pwm <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) r_pwm[i] <= (r_slot < r_act[i]);
    end
  end

  assign PWM_Out  = r_pwm;
  assign Sel_Ch   = r_sel;
  assign Sel_Duty = w_cur_duty;

endmodule
